// File: rtl/accel_pkg.sv
// ----------------------------------------------------------------------------
// accel_pkg
// Shared types and defaults for the accelerator datapath scheduler.
//   - default coordinate widths and raster limits
//   - coordinate typedefs sized to the defaults
//   - dispatcher state encoding
// ----------------------------------------------------------------------------
package accel_pkg;

    localparam int NUM_ENG_DEF = 4;
    localparam int XW_DEF      = 10;
    localparam int YW_DEF      = 10;
    localparam int X_LAST_DEF  = 1023;
    localparam int Y_LAST_DEF  = 767;

    typedef logic [XW_DEF-1:0] coord_x_t;
    typedef logic [YW_DEF-1:0] coord_y_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dispatch_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered priority pointer. Grants the first
// requester at or after the pointer; on advance the pointer moves to the
// position just past the granted requester.
// Ports:
//   clk      in  1  clock
//   rst      in  1  synchronous active-high reset (pointer -> 0)
//   req      in  N  request vector
//   advance  in  1  a grant was consumed this cycle; move the pointer
//   grant    out N  one-hot grant (zero when no request)
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next_ptr;
    logic [N-1:0]  w_mask;
    logic [N-1:0]  w_masked;
    logic [N-1:0]  w_pick;

    // Requests at/above the pointer take priority; if none, wrap to the
    // lowest requester overall. The lowest set bit of the chosen vector is
    // isolated with x & -x.
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_mask     = ~((N'(1) << r_ptr) - N'(1));
        w_masked   = req & w_mask;
        w_pick     = (|w_masked) ? w_masked : req;
        grant      = w_pick & (~w_pick + N'(1));
        w_next_ptr = r_ptr;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                w_next_ptr = PW'((i + 1) % N);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/pixel_job_dispatcher.sv
// ----------------------------------------------------------------------------
// pixel_job_dispatcher
// Frame-level scheduler: walks the raster (X fastest, then Y) and hands one
// pixel coordinate per cycle to a ready, idle iteration engine chosen
// round-robin. Tracks one outstanding job per engine and reports frame
// completion once every pixel has been issued and retired.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       pulse, begins a frame (IDLE only)
//   abort       pulse, stop issuing, drain, return to IDLE
//   eng_ready   engine i can accept a job this cycle
//   eng_done    engine i retires its job this cycle
//   eng_issue   one-hot job strobe to engine i (combinational)
//   job_x/y     coordinate broadcast with eng_issue
//   busy        high in SCAN and DRAIN
//   frame_done  pulse after a normal frame completes
//   aborted     pulse after an aborted frame has drained
//   err_done    sticky: retire seen on an engine with no job
// ----------------------------------------------------------------------------
module pixel_job_dispatcher
    import accel_pkg::*;
#(
    parameter int NUM_ENG = NUM_ENG_DEF,
    parameter int XW      = XW_DEF,
    parameter int YW      = YW_DEF,
    parameter int X_LAST  = X_LAST_DEF,
    parameter int Y_LAST  = Y_LAST_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [NUM_ENG-1:0] eng_ready,
    input  logic [NUM_ENG-1:0] eng_done,
    output logic [NUM_ENG-1:0] eng_issue,
    output logic [XW-1:0]      job_x,
    output logic [YW-1:0]      job_y,
    output logic               busy,
    output logic               frame_done,
    output logic               aborted,
    output logic               err_done
);

    dispatch_state_t    r_state;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic [NUM_ENG-1:0] r_outstanding;
    logic               r_abort_lat;
    logic               r_frame_done;
    logic               r_aborted;
    logic               r_err_done;

    logic               w_scan;
    logic [NUM_ENG-1:0] w_req;
    logic [NUM_ENG-1:0] w_grant;
    logic               w_issue;
    logic               w_x_last;
    logic               w_y_last;
    logic [NUM_ENG-1:0] w_stray;

    assign w_scan   = (r_state == SCAN);
    assign w_req    = eng_ready & ~r_outstanding & {NUM_ENG{w_scan}};
    assign w_issue  = |w_grant;
    assign w_x_last = (r_x == XW'(X_LAST));
    assign w_y_last = (r_y == YW'(Y_LAST));
    assign w_stray  = eng_done & ~r_outstanding;

    rr_arbiter #(.N(NUM_ENG)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .advance (w_issue),
        .grant   (w_grant)
    );

    assign eng_issue  = w_grant;
    assign job_x      = r_x;
    assign job_y      = r_y;
    assign busy       = (r_state == SCAN) || (r_state == DRAIN);
    assign frame_done = r_frame_done;
    assign aborted    = r_aborted;
    assign err_done   = r_err_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_outstanding <= '0;
            r_abort_lat   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_aborted     <= 1'b0;
            r_err_done    <= 1'b0;
        end else begin
            r_frame_done  <= 1'b0;
            r_aborted     <= 1'b0;
            // A retire frees the engine from the next cycle; a new issue
            // can only target an engine that was already free.
            r_outstanding <= (r_outstanding & ~eng_done) | w_grant;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= SCAN;
                        r_x         <= '0;
                        r_y         <= '0;
                        r_abort_lat <= 1'b0;
                        r_err_done  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (w_issue) begin
                        if (w_x_last) begin
                            r_x <= '0;
                            r_y <= w_y_last ? '0 : r_y + 1'b1;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                    // An issue coincident with abort still completes above.
                    if (abort) begin
                        r_state     <= DRAIN;
                        r_abort_lat <= 1'b1;
                    end else if (w_issue && w_x_last && w_y_last) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_outstanding == '0) begin
                        if (r_abort_lat) begin
                            r_state   <= IDLE;
                            r_aborted <= 1'b1;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_frame_done <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase

            // A stray retire is flagged even in the cycle a start clears it.
            if (|w_stray) begin
                r_err_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_job_dispatcher.sv
// ----------------------------------------------------------------------------
// tb_pixel_job_dispatcher
// Directed bench for pixel_job_dispatcher with a 4x2 raster and 4 engines.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_pixel_job_dispatcher;

    localparam int NE = 4;
    localparam int XL = 3;
    localparam int YL = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] eng_ready;
    logic [3:0] eng_done;
    logic [3:0] eng_issue;
    logic [9:0] job_x;
    logic [9:0] job_y;
    logic       busy;
    logic       frame_done;
    logic       aborted;
    logic       err_done;

    always #5 clk = ~clk;

    pixel_job_dispatcher #(
        .NUM_ENG (NE),
        .XW      (10),
        .YW      (10),
        .X_LAST  (XL),
        .Y_LAST  (YL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .eng_ready  (eng_ready),
        .eng_done   (eng_done),
        .eng_issue  (eng_issue),
        .job_x      (job_x),
        .job_y      (job_y),
        .busy       (busy),
        .frame_done (frame_done),
        .aborted    (aborted),
        .err_done   (err_done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Per-run record filled by run_frame
    int iss_eng[$];
    int iss_x[$];
    int iss_y[$];
    int iss_cyc[$];
    int cnt[NE];
    int n_fd, n_ab, fd_cyc, last_done_cyc, last_done_busy, viol, timed_out;

    function automatic int onehot_idx(input logic [3:0] v);
        int r = -1;
        int c = 0;
        for (int i = 0; i < NE; i++) begin
            if (v[i]) begin
                r = i;
                c++;
            end
        end
        return (c == 1) ? r : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a frame and plays the engines: each engine retires 'lat' cycles
    // after it was issued. abort_at >= 0 raises abort in the cycle entered
    // with that many issues seen; stop_at >= 0 returns once that many issues
    // are seen. Always returns 1 ns after a rising edge.
    task automatic run_frame(input logic [3:0] rdy, input int lat,
                             input int abort_at, input int stop_at);
        int  cyc = 0;
        int  idle = 0;
        int  e;
        bit  seen_busy = 0;
        bit  abort_sent = 0;
        iss_eng.delete(); iss_x.delete(); iss_y.delete(); iss_cyc.delete();
        for (int i = 0; i < NE; i++) cnt[i] = 0;
        n_fd = 0; n_ab = 0; fd_cyc = -1; last_done_cyc = -1; last_done_busy = 0;
        viol = 0; timed_out = 0;
        eng_ready = rdy;
        eng_done  = '0;
        abort     = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        while (1) begin
            cyc++;
            if (stop_at >= 0 && iss_eng.size() == stop_at) break;
            if (cyc > 200) begin
                timed_out = 1;
                break;
            end
            for (int i = 0; i < NE; i++) eng_done[i] = (cnt[i] == 1);
            abort = (abort_at >= 0) && !abort_sent && (iss_eng.size() == abort_at);
            if (abort) abort_sent = 1;
            @(negedge clk);
            if (eng_done != '0) begin
                last_done_cyc  = cyc;
                last_done_busy = busy;
            end
            if (frame_done) begin
                n_fd++;
                fd_cyc = cyc;
            end
            if (aborted) n_ab++;
            if (eng_issue != '0) begin
                e = onehot_idx(eng_issue);
                if (e < 0) begin
                    viol++;
                end else begin
                    if (cnt[e] != 0) viol++;
                    cnt[e] = lat + 1;
                    iss_eng.push_back(e);
                    iss_x.push_back(int'(job_x));
                    iss_y.push_back(int'(job_y));
                    iss_cyc.push_back(cyc);
                end
            end
            for (int i = 0; i < NE; i++) if (cnt[i] > 0) cnt[i]--;
            if (busy) seen_busy = 1;
            else if (seen_busy) idle++;
            tick();
            if (idle == 4) break;
        end
        abort    = 1'b0;
        eng_done = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0; eng_ready = '0; eng_done = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_issue", eng_issue, 0);
        check("rst_x", job_x, 0);
        check("rst_y", job_y, 0);
        check("rst_busy", busy, 0);
        check("rst_fd", frame_done, 0);
        check("rst_ab", aborted, 0);
        check("rst_err", err_done, 0);
        tick();

        // 1) all ready, 3-cycle latency: raster order, grants 0,1,2,3,0,...
        run_frame(4'b1111, 3, -1, -1);
        check("t1_timeout", timed_out, 0);
        check("t1_count", iss_eng.size(), 8);
        for (int i = 0; i < iss_eng.size() && i < 8; i++) begin
            check($sformatf("t1_eng%0d", i), iss_eng[i], i % 4);
            check($sformatf("t1_x%0d", i), iss_x[i], i % 4);
            check($sformatf("t1_y%0d", i), iss_y[i], i / 4);
        end
        check("t1_viol", viol, 0);
        check("t1_fd", n_fd, 1);
        check("t1_ab", n_ab, 0);
        check("t1_fd_after_done", (fd_cyc > last_done_cyc) && (fd_cyc <= last_done_cyc + 4), 1);

        // 2) only engine 2 ready: one job per 4-cycle round trip
        run_frame(4'b0100, 3, -1, -1);
        check("t2_timeout", timed_out, 0);
        check("t2_count", iss_eng.size(), 8);
        for (int i = 0; i < iss_eng.size() && i < 8; i++) begin
            check($sformatf("t2_eng%0d", i), iss_eng[i], 2);
            check($sformatf("t2_x%0d", i), iss_x[i], i % 4);
            check($sformatf("t2_y%0d", i), iss_y[i], i / 4);
            if (i > 0) check($sformatf("t2_gap%0d", i), iss_cyc[i] - iss_cyc[i-1], 4);
        end
        check("t2_viol", viol, 0);
        check("t2_fd", n_fd, 1);

        // 4) abort in IDLE ignored; start+abort in IDLE starts; start in SCAN ignored
        eng_ready = 4'b0001;
        abort = 1'b1;
        @(negedge clk);
        check("t4_idle_abort_busy", busy, 0);
        check("t4_idle_abort_issue", eng_issue, 0);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("t4_after_abort_busy", busy, 0);
        check("t4_after_abort_x", job_x, 0);
        check("t4_after_abort_y", job_y, 0);
        tick();
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        check("t4_sa_busy_pre", busy, 0);
        tick();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("t4_sa_busy", busy, 1);
        check("t4_sa_issue", eng_issue, 4'b0001);
        check("t4_sa_x", job_x, 0);
        check("t4_sa_y", job_y, 0);
        tick();
        start = 1'b1;
        @(negedge clk);
        check("t4_scan_start_issue", eng_issue, 0);
        check("t4_scan_start_x", job_x, 1);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("t4_scan_after_x", job_x, 1);
        check("t4_scan_after_y", job_y, 0);
        check("t4_scan_after_busy", busy, 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        eng_done = 4'b0001;
        tick();
        eng_done = 4'b0000;
        n_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (aborted) n_seen++;
            check($sformatf("t4_drain_fd%0d", i), frame_done, 0);
            tick();
        end
        check("t4_aborted", n_seen, 1);
        @(negedge clk);
        check("t4_end_busy", busy, 0);
        check("t4_end_err", err_done, 0);
        tick();

        // 3) abort coincident with the 5th issue, 2 jobs left outstanding
        run_frame(4'b1111, 2, 4, -1);
        check("t3_timeout", timed_out, 0);
        check("t3_count", iss_eng.size(), 5);
        for (int i = 0; i < iss_eng.size() && i < 5; i++) begin
            check($sformatf("t3_eng%0d", i), iss_eng[i], (i + 1) % 4);
        end
        check("t3_busy_last_done", last_done_busy, 1);
        check("t3_ab", n_ab, 1);
        check("t3_fd", n_fd, 0);
        check("t3_viol", viol, 0);

        // 5) stray retire on engine 1: sticky error, bookkeeping untouched
        eng_done = 4'b0010;
        tick();
        eng_done = 4'b0000;
        @(negedge clk);
        check("t5_err_set", err_done, 1);
        tick();
        @(negedge clk);
        check("t5_err_sticky", err_done, 1);
        tick();
        eng_ready = 4'b0010;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("t5_err_cleared", err_done, 0);
        check("t5_issue_eng1", eng_issue, 4'b0010);
        check("t5_x", job_x, 0);
        check("t5_y", job_y, 0);
        tick();

        // 6) reset mid-frame, then a reset in SCAN at (2,1), then restart
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_frame(4'b1111, 3, -1, 6);
        check("t6_pre_count", iss_eng.size(), 6);
        check("t6_pre_x", job_x, 2);
        check("t6_pre_y", job_y, 1);
        check("t6_pre_busy", busy, 1);
        rst = 1'b1;
        eng_done = '0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_issue", eng_issue, 0);
        check("t6_rst_x", job_x, 0);
        check("t6_rst_y", job_y, 0);
        check("t6_rst_fd", frame_done, 0);
        check("t6_rst_ab", aborted, 0);
        check("t6_rst_err", err_done, 0);
        tick();
        run_frame(4'b1111, 3, -1, -1);
        check("t6_timeout", timed_out, 0);
        check("t6_count", iss_eng.size(), 8);
        if (iss_eng.size() > 0) begin
            check("t6_first_eng", iss_eng[0], 0);
            check("t6_first_x", iss_x[0], 0);
            check("t6_first_y", iss_y[0], 0);
        end
        check("t6_fd", n_fd, 1);
        check("t6_viol", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
